branch_feedback_queue: RTL

In-order queue of in-flight conditional-branch predictions. Sits between fetch/decode and the direction predictor.
- Fetch side enqueues (pc, target, prediction) when the predictor answers.
- Execute side resolves the oldest entry with the actual outcome.
- Block produces the registered feedback bundle (i_fb_* of the predictor), a mispredict pulse and a redirect PC, and squashes wrong-path entries.

---
 rtl/mips_core_pkg.sv | 24 ++
 rtl/bfq_storage.sv | 36 +++
 rtl/branch_feedback_queue.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome enum, queue entry struct and the delay-slot fall-through helper.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef struct packed {
    logic [`ADDR_WIDTH-1:0] pc;
    logic [`ADDR_WIDTH-1:0] target;
    BranchOutcome           prediction;
  } bfq_entry_t;

  // Branch plus delay slot: the next sequential fetch after a not-taken branch.
  function automatic logic [`ADDR_WIDTH-1:0] bfq_fallthrough(input logic [`ADDR_WIDTH-1:0] pc);
    return pc + `ADDR_WIDTH'(8);
  endfunction

endpackage

// File: rtl/bfq_storage.sv
// Entry array for the branch feedback queue: one write port at the tail, combinational read at the head.
module bfq_storage
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  bfq_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output bfq_entry_t               rdata
);

  localparam int PW = $clog2(DEPTH);

  bfq_entry_t entries [DEPTH];

  // Entries carry no reset: their contents are meaningless until written.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      bfq_entry_t entry_reg;

      always_ff @(posedge clk) begin
        if (we && (waddr == PW'(gi))) begin
          entry_reg <= wdata;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign rdata = entries[raddr];

endmodule

// File: rtl/branch_feedback_queue.sv
// In-order queue of in-flight branch predictions with registered predictor feedback and redirect.
// Optional macro BRANCH_FB_STATS_EN adds saturating resolved/mispredicted counters.
module branch_feedback_queue
  import mips_core_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_enq_valid,
  input  logic [ADDR_WIDTH-1:0]    i_enq_pc,
  input  logic [ADDR_WIDTH-1:0]    i_enq_target,
  input  BranchOutcome             i_enq_prediction,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  input  logic                     i_res_valid,
  input  logic [ADDR_WIDTH-1:0]    i_res_pc,
  input  BranchOutcome             i_res_outcome,
  input  logic                     i_flush,
  output logic                     o_fb_valid,
  output logic [ADDR_WIDTH-1:0]    o_fb_pc,
  output BranchOutcome             o_fb_prediction,
  output BranchOutcome             o_fb_outcome,
  output logic                     o_mispredict,
  output logic [ADDR_WIDTH-1:0]    o_redirect_pc,
`ifdef BRANCH_FB_STATS_EN
  output logic [31:0]              o_stat_resolved,
  output logic [31:0]              o_stat_mispredicted,
`endif
  output logic                     o_desync
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;
  bfq_entry_t    head_entry, enq_entry;

  logic res_fire, res_match, res_desync, res_mispredict, squash, enq_accept;
  logic [ADDR_WIDTH-1:0] redirect_next;

  assign enq_entry = '{pc: i_enq_pc, target: i_enq_target, prediction: i_enq_prediction};

  bfq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (enq_accept),
    .waddr (tail_reg),
    .wdata (enq_entry),
    .raddr (head_reg),
    .rdata (head_entry)
  );

  always_comb begin
    res_fire       = i_res_valid && (count_reg != '0);
    res_match      = res_fire && (i_res_pc == head_entry.pc);
    res_desync     = res_fire && !res_match;
    // A flush owns the redirect, so a same-cycle wrong direction is not reported as mispredict.
    res_mispredict = res_match && !i_flush && (head_entry.prediction != i_res_outcome);
    squash         = i_flush || res_desync || res_mispredict;
    enq_accept     = i_enq_valid && !squash && ((count_reg != CW'(DEPTH)) || res_match);
    redirect_next  = (i_res_outcome == TAKEN) ? head_entry.target : bfq_fallthrough(head_entry.pc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (squash) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + PW'(res_match);
      tail_reg  <= tail_reg + PW'(enq_accept);
      count_reg <= count_reg + CW'(enq_accept) - CW'(res_match);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_fb_valid      <= 1'b0;
      o_fb_pc         <= '0;
      o_fb_prediction <= NOT_TAKEN;
      o_fb_outcome    <= NOT_TAKEN;
      o_mispredict    <= 1'b0;
      o_redirect_pc   <= '0;
      o_desync        <= 1'b0;
    end else begin
      o_fb_valid   <= res_match;
      o_mispredict <= res_mispredict;
      o_desync     <= res_desync;
      if (res_match) begin
        o_fb_pc         <= head_entry.pc;
        o_fb_prediction <= head_entry.prediction;
        o_fb_outcome    <= i_res_outcome;
      end
      if (res_mispredict) begin
        o_redirect_pc <= redirect_next;
      end
    end
  end

`ifdef BRANCH_FB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_stat_resolved     <= '0;
      o_stat_mispredicted <= '0;
    end else begin
      if (o_fb_valid && (o_stat_resolved != '1)) begin
        o_stat_resolved <= o_stat_resolved + 32'd1;
      end
      if (o_mispredict && (o_stat_mispredicted != '1)) begin
        o_stat_mispredicted <= o_stat_mispredicted + 32'd1;
      end
    end
  end
`endif

  assign o_full  = (count_reg == CW'(DEPTH));
  assign o_count = count_reg;

endmodule
